// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : Multi-cycle radix-2 shift-add multiply sequencer. Accepts an
//                operand pair on start and processes one multiplier bit per
//                cycle on operand magnitudes. It then applies a sign fix-up
//                and delivers a registered 2*WIDTH product as hi/lo. busy
//                stalls the pipeline while an operation is in flight, and
//                cancel aborts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0]   c_OP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] c_ACC_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      c_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      c_CNT_LAST = CW'(WIDTH-1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nx;
   logic                 w_accept;
   logic                 w_commit;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_count;
   logic                 r_neg;
   logic                 r_busy;
   logic                 r_done;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_addend;
   logic [2*WIDTH-1:0]   w_result;

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
   assign w_mag_a  = (is_signed && op_a[WIDTH-1]) ? (~op_a + c_OP_ONE) : op_a;
   assign w_mag_b  = (is_signed && op_b[WIDTH-1]) ? (~op_b + c_OP_ONE) : op_b;
   assign w_addend = {{WIDTH{1'b0}}, r_mcand} << r_count;
   assign w_result = r_neg ? (~r_acc + c_ACC_ONE) : r_acc;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state decode; cancel always wins and forces a return to IDLE.
   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_commit   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !cancel) begin
               w_accept   = 1'b1;
               w_state_nx = S_CALC;
            end
         end
         S_CALC: begin
            if (cancel) begin
               w_state_nx = S_IDLE;
            end else if (r_count == c_CNT_LAST) begin
               w_state_nx = S_FIX;
            end
         end
         S_FIX: begin
            w_state_nx = S_IDLE;
            w_commit   = !cancel;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, shift-add iteration, result and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_neg    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_busy <= (w_state_nx != S_IDLE);
         r_done <= w_commit;
         if (w_accept) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
         end else if (r_state == S_CALC && !cancel) begin
            if (r_mplier[0]) begin
               r_acc <= r_acc + w_addend;
            end
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + c_CNT_ONE;
         end
         if (w_commit) begin
            r_hi <= w_result[2*WIDTH-1:WIDTH];
            r_lo <= w_result[WIDTH-1:0];
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq_ctrl
//  Description : Self-checking bench for mul_seq_ctrl. Directed corners plus
//                random operands, with results computed by plain 64-bit
//                arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         is_signed = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         cancel = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int vectors = 0;
   int errors  = 0;

   mul_seq_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .op_a(op_a), .op_b(op_b), .cancel(cancel),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference product from the arithmetic definition.
   function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
      logic signed [63:0] sa, sb;
      if (s) begin
         sa = {{W{a[W-1]}}, a};
         sb = {{W{b[W-1]}}, b};
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Issue one multiply and watch 40 cycles; optionally inject a second start
   // (while busy) five cycles in.
   task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit inject);
      logic [63:0] exp;
      int nb, nd, lat;
      logic [W-1:0] got_hi, got_lo;
      exp = ref_mul(a, b, s);
      nb = 0; nd = 0; lat = -1; got_hi = '0; got_lo = '0;
      op_a = a; op_b = b; is_signed = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op_a = $urandom; op_b = $urandom; is_signed = $urandom_range(0, 1);
      for (int i = 0; i <= 40; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         if (busy) nb++;
         if (done) begin
            nd++;
            if (nd == 1) begin
               lat = i; got_hi = hi; got_lo = lo;
            end
         end
         if (inject && i == 5) begin
            start = 1'b1; op_a = 32'd2; op_b = 32'd2; is_signed = 1'b0;
         end
         if (inject && i == 6) start = 1'b0;
      end
      check({tag, "_lat"}, 64'(lat), 64'd33);
      check({tag, "_ndone"}, 64'(nd), 64'd1);
      check({tag, "_nbusy"}, 64'(nb), 64'd33);
      check({tag, "_prod"}, {got_hi, got_lo}, exp);
   endtask

   initial begin
      logic [W-1:0] keep_hi, keep_lo;
      int nd;

      // Reset state
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed corners
      run_mul("u_small", 32'd7, 32'd6, 1'b0, 1'b0);
      run_mul("u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_mul("s_m2x3", 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
      run_mul("s_min2", 32'h80000000, 32'h80000000, 1'b1, 1'b0);
      run_mul("s_m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
      run_mul("s_minx1", 32'h80000000, 32'd1, 1'b1, 1'b0);
      run_mul("busy_start", 32'd7, 32'd6, 1'b0, 1'b1);

      // cancel together with start in IDLE: start ignored
      op_a = 32'd9; op_b = 32'd9; start = 1'b1; cancel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      check("cs_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("cs_busy2", 64'(busy), 64'd0);

      // Cancel mid-operation
      keep_hi = hi; keep_lo = lo; nd = 0;
      op_a = 32'd5; op_b = 32'd5; is_signed = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) nd++;
         if (i == 10) cancel = 1'b1;
         if (i == 11) begin
            cancel = 1'b0;
            check("cancel_busy", 64'(busy), 64'd0);
         end
      end
      check("cancel_ndone", 64'(nd), 64'd0);
      check("cancel_hilo", {hi, lo}, {keep_hi, keep_lo});
      run_mul("after_cancel", 32'd3, 32'd4, 1'b0, 1'b0);

      // Asynchronous reset mid-operation
      op_a = 32'd123; op_b = 32'd456; is_signed = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_hilo", {hi, lo}, 64'd0);
      #3;
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) nd++;
      end
      check("arst_quiet", 64'(nd), 64'd0);

      // Random operands
      for (int k = 0; k < 16; k++) begin
         run_mul("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
